// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned W_DEF = 8;

    // Bit index counter width for a W-bit operand.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sum1b.sv
// 1-bit full-adder cell with propagate/generate outputs.
module sum1b (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o,
    output logic p_o,
    output logic g_o
);

    assign p_o  = a_i ^ b_i;
    assign g_o  = a_i & b_i;
    assign s_o  = p_o ^ ci_i;
    assign co_o = g_o | (p_o & ci_i);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial W-bit add/subtract sequencer: one full-adder cell, one bit per clock, LSB first.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         prop_all
);

    localparam int unsigned CntW = cnt_width(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            pacc_q, pacc_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;
    logic            prop_all_q, prop_all_d;

    logic cell_s, cell_co, cell_p, g_unused;

    sum1b u_cell (
        .a_i  (op_a_q[0]),
        .b_i  (op_b_q[0]),
        .ci_i (carry_q),
        .s_o  (cell_s),
        .co_o (cell_co),
        .p_o  (cell_p),
        .g_o  (g_unused)
    );

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        pacc_d     = pacc_q;
        sum_d      = sum_q;
        c_out_d    = c_out_q;
        ovf_d      = ovf_q;
        prop_all_d = prop_all_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Subtract as a + ~b + 1: invert B and seed the carry.
                    op_a_d  = a;
                    op_b_d  = b ^ {W{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    pacc_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                res_d   = {cell_s, res_q[W-1:1]};
                carry_d = cell_co;
                pacc_d  = pacc_q & cell_p;
                if (cnt_q == CntLast) begin
                    // carry_q here is the carry into the MSB.
                    sum_d      = res_d;
                    c_out_d    = cell_co;
                    ovf_d      = carry_q ^ cell_co;
                    prop_all_d = pacc_d;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            pacc_q     <= 1'b0;
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
            prop_all_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            pacc_q     <= pacc_d;
            sum_q      <= sum_d;
            c_out_q    <= c_out_d;
            ovf_q      <= ovf_d;
            prop_all_q <= prop_all_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign ovf      = ovf_q;
    assign prop_all = prop_all_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: stimulus pushes expected results, a monitor checks on done.
module tb_serial_add_seq;

    localparam int unsigned W = 8;
    localparam int unsigned Latency = W + 1;

    logic         clk, rst, start, sub;
    logic [W-1:0] a, b, sum;
    logic         busy, done, c_out, ovf, prop_all;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         p;
        int           t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    serial_add_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .prop_all (prop_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int t);
        exp_t e;
        int ux, uy, ur, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur  = ux - uy;
            sr  = sx - sy;
            e.c = (ux >= uy);
        end else begin
            ur  = ux + uy;
            sr  = sx + sy;
            e.c = (ur >= (1 << W));
        end
        e.sum = ur[W-1:0];
        e.v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.p   = &(x ^ (s ? ~y : y));
        e.t   = t;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b required idle", busy, done);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        wait_idle();
        @(negedge clk);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        sb.push_back(model(x, y, s, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compares every done pulse against the oldest expected entry.
    logic         hold_chk = 1'b0;
    logic [W-1:0] hold_sum;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold_chk) begin
                check("sum_hold", 32'(sum), 32'(hold_sum));
                hold_chk = 1'b0;
            end
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 required no pending op");
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("c_out", 32'(c_out), 32'(e.c));
                    check("ovf", 32'(ovf), 32'(e.v));
                    check("prop_all", 32'(prop_all), 32'(e.p));
                    check("latency", 32'(cyc - e.t), 32'(Latency));
                    hold_chk = 1'b1;
                    hold_sum = e.sum;
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_prop_all", 32'(prop_all), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'h35, 8'h4A, 1'b0);
        issue(8'h7F, 8'h01, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'h10, 8'h20, 1'b1);
        issue(8'h80, 8'h01, 1'b1);
        issue(8'h55, 8'hAA, 1'b0);
        issue(8'h55, 8'hAB, 1'b0);

        // A start pulse mid-RUN must be ignored.
        issue(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", 32'(busy), 32'd1);

        // Reset in cycle 5 of RUN abandons the operation and clears outputs.
        issue(8'h9C, 8'h3B, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_c_out", 32'(c_out), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_prop_all", 32'(prop_all), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);
        check("idle_after_rst_done", 32'(done), 32'd0);

        issue(8'hA5, 8'h5A, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial W-bit add/subtract sequencer built around a single 1-bit full-adder cell with propagate/generate outputs. It accepts two operands on a start pulse and runs them through the cell one bit per clock, LSB first. It returns the sum, carry-out, signed overflow and a group-propagate flag with a one-cycle done pulse. It is the area-minimal arithmetic option next to the parallel ripple/lookahead adders in the arithmetic library.

## Interface
- W, default 8: operand width in bits; legal range 2..32.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- sum  output  W  result; held from DONE until the next accepted start.
- c_out  output  1  final carry; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- prop_all  output  1  AND of per-bit P over all W bits.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: W cycles, one bit processed per cycle.
  - DONE: one cycle, then back to IDLE.
- IDLE, start=1 accepts the request:
  - opA <= a; opB <= b XOR {W{sub}}; carry <= sub; cnt <= 0; pacc <= 1.
  - Next state RUN.
- RUN, each cycle:
  - Cell inputs are opA[0], opB[0], carry.
  - opA and opB shift right by 1.
  - The sum bit shifts into res from the MSB side, so res ends LSB-aligned.
  - carry <= cell c_out; pacc <= pacc & P.
  - When cnt == W-1: latch cin_msb (the carry presented at bit W-1) and go to DONE. Otherwise cnt <= cnt+1.
- DONE:
  - done=1.
  - sum = res, c_out = carry, ovf = cin_msb ^ carry, prop_all = pacc.
  - Next state IDLE.
- start is ignored in RUN and DONE; there is no queueing.
- sum, c_out, ovf and prop_all are registered. They update only on the RUN→DONE edge and stay stable until then.
- Asserting rst in any state, including mid-RUN, forces IDLE immediately. The operation is abandoned and outputs clear.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, prop_all=0; state IDLE; cnt=0.
- Start sampled at edge 0 → busy=1 for cycles 1..W → done=1 in cycle W+1 → IDLE in cycle W+2.
- Earliest next accepted start is sampled at edge W+2. Throughput is one operation per W+2 cycles.
- Latency from start to done is W+1 cycles (9 for W=8).
- busy and done are never high together.
- Arithmetic is modulo 2^W. Carry and overflow are reported only through c_out and ovf.

## Structure
- Package serial_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default width constant W_DEF=8;
  - counter width localparam rule, $clog2(W).
- Exactly one sub-module: the existing 1-bit full-adder cell sum1b, instantiated once.
  - Its P output feeds pacc. G is left unused.
- The sequencer holds the FSM, operand shift registers, carry flop, counter and result register.

## Test plan
All scenarios use W=8.
- Add, 0x35 + 0x4A → sum=0x7F, c_out=0, ovf=0, prop_all=0; done exactly 9 cycles after start.
- Signed overflow, 0x7F + 0x01 → sum=0x80, c_out=0, ovf=1.
- Unsigned wrap, 0xFF + 0x01 → sum=0x00, c_out=1, ovf=0.
- Subtract:
  - 0x10 - 0x20 → sum=0xF0, c_out=0 (borrow), ovf=0.
  - 0x80 - 0x01 → sum=0x7F, ovf=1.
- Propagate flag:
  - 0x55 + 0xAA → sum=0xFF, prop_all=1.
  - Then 0x55 + 0xAB → prop_all=0.
- Control edge cases:
  - Pulse start again in cycle 3 of RUN with different operands → ignored; original result returned.
  - Assert rst in cycle 5 of RUN → all outputs 0 in the same cycle and state IDLE.
  - A new start after reset completes normally.
